// File: rtl/inverter_chain_checker_if.sv
// Control/status interface for inverter_chain_checker.
// Purpose: carries the run request, the channel enable mask and the per-run
// result signals between a controller (master) and the checker (slave).
// Signals:
//   start        master -> slave  run request, sampled while the checker is idle
//   chan_mask    master -> slave  per-channel enable, captured with start
//   busy         slave -> master  run in progress
//   done         slave -> master  one-cycle end-of-run pulse
//   pass         slave -> master  run finished with no errors and no timeout
//   timeout      slave -> master  a settle wait ran out during the run
//   err_count    slave -> master  saturating error count for the run
//   max_latency  slave -> master  worst settle latency of the run, in cycles
interface inverter_chain_checker_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic                start;
    logic [CHANNELS-1:0] chan_mask;
    logic                busy;
    logic                done;
    logic                pass;
    logic                timeout;
    logic [CNT_W-1:0]    err_count;
    logic [CNT_W-1:0]    max_latency;

    modport master (
        output start, chan_mask,
        input  busy, done, pass, timeout, err_count, max_latency
    );

    modport slave (
        input  start, chan_mask,
        output busy, done, pass, timeout, err_count, max_latency
    );
endinterface

// File: rtl/inverter_chain_checker.sv
// inverter_chain_checker
// Purpose: drives CHANNELS external inverter chains with NUM_TOGGLES handshaked
// stimulus toggles per run and checks every response: polarity, worst-case
// settle latency, glitches (a channel settling and then leaving) and timeouts.
// Ports:
//   clk    in   sampling/stimulus clock
//   rst_n  in   asynchronous active-low reset
//   ctl    slave modport of inverter_chain_checker_if (start, chan_mask in;
//          busy, done, pass, timeout, err_count, max_latency out)
//   resp   in   chain outputs, asynchronous to clk
//   stim   out  chain inputs
module inverter_chain_checker #(
    parameter int CHANNELS    = 4,
    parameter int STAGES      = 5,
    parameter int NUM_TOGGLES = 8,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    inverter_chain_checker_if.slave   ctl,
    input  logic [CHANNELS-1:0]       resp,
    output logic [CHANNELS-1:0]       stim
);

    // An odd number of stages inverts the stimulus.
    localparam logic INVERTS = (STAGES % 2) != 0;
    localparam int   TOG_W   = $clog2(NUM_TOGGLES + 1);
    localparam int   SUM_W   = CNT_W + 1;
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        PRECHECK,
        DRIVE,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] rsync;
    logic [CHANNELS-1:0] mask_q;
    logic [CHANNELS-1:0] stim_q;
    logic [CHANNELS-1:0] seen_q;
    logic [CHANNELS-1:0] flagged_q;
    logic [CNT_W-1:0]    lat_q;
    logic [CNT_W-1:0]    err_q;
    logic [CNT_W-1:0]    maxlat_q;
    logic [TOG_W-1:0]    tog_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic                timeout_q;

    logic [CHANNELS-1:0] exp_resp;
    logic [CHANNELS-1:0] settled;
    logic [CHANNELS-1:0] glitch_new;
    logic                all_settled;
    logic                lat_expired;
    logic                wait_timeout;
    logic [SUM_W-1:0]    glitch_cnt;
    logic [SUM_W-1:0]    err_sum;
    logic [CNT_W-1:0]    err_wait;
    logic [CNT_W-1:0]    err_plus1;

    assign stim            = stim_q;
    assign ctl.busy        = busy_q;
    assign ctl.done        = done_q;
    assign ctl.pass        = pass_q;
    assign ctl.timeout     = timeout_q;
    assign ctl.err_count   = err_q;
    assign ctl.max_latency = maxlat_q;

    // Two-flop synchroniser for the asynchronous chain outputs; every check
    // below looks only at rsync, so measured latency includes these two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            rsync <= '0;
        end else begin
            sync1 <= resp;
            rsync <= sync1;
        end
    end

    // Settle detection, glitch detection and the saturating error arithmetic.
    // Disabled channels always read as settled so they never hold up a wait.
    // A glitch is a channel that already settled in this wait and has now
    // dropped out again; each channel is reported at most once per wait.
    always_comb begin
        exp_resp     = stim_q ^ {CHANNELS{INVERTS}};
        settled      = ~(rsync ^ exp_resp) | ~mask_q;
        all_settled  = &settled;
        lat_expired  = (lat_q == CNT_W'(TIMEOUT));
        wait_timeout = !all_settled && lat_expired;
        glitch_new   = seen_q & ~settled & ~flagged_q & mask_q;
        glitch_cnt   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            glitch_cnt = glitch_cnt + SUM_W'(glitch_new[i]);
        end
        err_sum   = SUM_W'(err_q) + glitch_cnt + SUM_W'(wait_timeout);
        err_wait  = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[CNT_W-1:0];
        err_plus1 = (err_q == ERR_MAX) ? ERR_MAX : err_q + CNT_W'(1);
    end

    // Run sequencer. PRECHECK makes sure the chains agree with the current
    // stimulus before the first toggle, DRIVE flips all enabled channels,
    // WAIT times the response. A timeout aborts the run with stim left as is.
    // The done pulse and the final pass flag appear on the edge leaving DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask_q    <= '0;
            stim_q    <= '0;
            seen_q    <= '0;
            flagged_q <= '0;
            lat_q     <= '0;
            err_q     <= '0;
            maxlat_q  <= '0;
            tog_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctl.start) begin
                        mask_q    <= ctl.chan_mask;
                        err_q     <= '0;
                        timeout_q <= 1'b0;
                        maxlat_q  <= '0;
                        pass_q    <= 1'b0;
                        lat_q     <= '0;
                        tog_q     <= '0;
                        busy_q    <= 1'b1;
                        state     <= (ctl.chan_mask == '0) ? DONE : PRECHECK;
                    end
                end

                PRECHECK: begin
                    if (all_settled) begin
                        state <= DRIVE;
                    end else if (lat_expired) begin
                        timeout_q <= 1'b1;
                        err_q     <= err_plus1;
                        state     <= DONE;
                    end else begin
                        lat_q <= lat_q + CNT_W'(1);
                    end
                end

                DRIVE: begin
                    stim_q    <= stim_q ^ mask_q;
                    lat_q     <= '0;
                    seen_q    <= '0;
                    flagged_q <= '0;
                    state     <= WAIT;
                end

                WAIT: begin
                    err_q     <= err_wait;
                    flagged_q <= flagged_q | glitch_new;
                    seen_q    <= seen_q | (settled & mask_q);
                    // Settling on the last allowed cycle still counts as settled.
                    if (all_settled) begin
                        if (lat_q > maxlat_q) begin
                            maxlat_q <= lat_q;
                        end
                        tog_q <= tog_q + TOG_W'(1);
                        state <= (tog_q == TOG_W'(NUM_TOGGLES - 1)) ? DONE : DRIVE;
                    end else if (lat_expired) begin
                        timeout_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        lat_q <= lat_q + CNT_W'(1);
                    end
                end

                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    pass_q <= (err_q == '0) && !timeout_q;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
